// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings,
// the hard-wired zero register and the control-field values of a NOP.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } ctrl_state_e;

    localparam logic [4:0] REG_ZERO     = 5'd0;
    localparam logic       NOP_WB_EN    = 1'b0;
    localparam logic       NOP_MEM_R_EN = 1'b0;

    // A producer only conflicts with a reader when it writes a real register.
    function automatic logic reg_conflict(input logic [4:0] dest, input logic [4:0] src);
        return (dest != REG_ZERO) && (dest == src);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Watchdog counter for cycles spent waiting on data memory; expired_o marks
// the last permitted wait cycle.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clear_i) begin
            wait_cnt_d = '0;
        end else if (inc_i) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expired_o = (wait_cnt_q == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken-branch and
// memory-wait handling. Optional perf counters enabled by PIPE_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic             ex_mem_r_en,
    input  logic [4:0]       ex_dest,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             stall_if,
    output logic             stall_id,
    output logic             flush_if,
    output logic             bubble_ex,
    output logic             stall_mem,
    output logic             bubble_wb,
    output logic             mem_err,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_e state_q, state_d;
    logic        mem_err_q, mem_err_d;
    logic        freeze, load_use;
    logic        timer_clear, timer_inc, timer_expired;

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (timer_clear),
        .inc_i     (timer_inc),
        .expired_o (timer_expired)
    );

    assign freeze = ((state_q == ST_RUN) && mem_req && !mem_ready)
                  || ((state_q == ST_MEM_WAIT) && !mem_ready)
                  || (state_q == ST_ERR);

    assign load_use = ex_mem_r_en
                   && (reg_conflict(ex_dest, id_src1)
                       || (id_two_src && reg_conflict(ex_dest, id_src2)));

    always_comb begin
        state_d     = state_q;
        mem_err_d   = mem_err_q;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        flush_if    = 1'b0;
        bubble_ex   = 1'b0;
        stall_mem   = 1'b0;
        bubble_wb   = 1'b0;

        // Freeze outranks the branch, so a redirect seen mid-wait is replayed once memory returns.
        if (!rst) begin
            if (freeze) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_mem = 1'b1;
                bubble_wb = 1'b1;
            end else if (br_taken) begin
                flush_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (load_use) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d   = ST_MEM_WAIT;
                    timer_inc = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d     = ST_RUN;
                    timer_clear = 1'b1;
                end else if (timer_expired) begin
                    state_d     = ST_ERR;
                    mem_err_d   = 1'b1;
                    timer_clear = 1'b1;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err    = mem_err_q;
    assign ctrl_state = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_cnt_d    = flush_cnt_q;
        if (stall_if && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
        if (flush_if && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_cnt_q    <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_cnt_q    <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_cnt    = flush_cnt_q;
`else
    assign stall_cycles = '0;
    assign flush_cnt    = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-level behavioural model
// checked on every falling edge, plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_src1, id_src2, ex_dest;
    logic             id_two_src, ex_mem_r_en, br_taken, mem_req, mem_ready;
    logic             stall_if, stall_id, flush_if, bubble_ex, stall_mem, bubble_wb, mem_err;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles, flush_cnt;

    int checkCount = 0;
    int failCount  = 0;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .ex_mem_r_en  (ex_mem_r_en),
        .ex_dest      (ex_dest),
        .br_taken     (br_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .stall_if     (stall_if),
        .stall_id     (stall_id),
        .flush_if     (flush_if),
        .bubble_ex    (bubble_ex),
        .stall_mem    (stall_mem),
        .bubble_wb    (bubble_wb),
        .mem_err      (mem_err),
        .ctrl_state   (ctrl_state),
        .stall_cycles (stall_cycles),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: the controller is either running, waiting on memory (with a count of
    // elapsed wait cycles), or dead; perf counts follow the observed control outputs.
    int               modelState  = 0;
    int               waitElapsed = 0;
    bit               modelErr    = 1'b0;
    logic [CNT_W-1:0] modelStalls = '0;
    logic [CNT_W-1:0] modelFlush  = '0;

    always @(negedge clk) begin
        bit frozen, hazard, eStall, eFlush, eBubbleEx, eMem;
        frozen = (modelState == 2)
              || (modelState == 1 && !mem_ready)
              || (modelState == 0 && mem_req && !mem_ready);
        hazard = ex_mem_r_en && ex_dest != 5'd0
              && (ex_dest == id_src1 || (id_two_src && ex_dest == id_src2));
        eMem      = !rst && frozen;
        eFlush    = !rst && !frozen && br_taken;
        eStall    = !rst && (frozen || (!br_taken && hazard));
        eBubbleEx = !rst && !frozen && (br_taken || hazard);

        checkOutput("stall_if",   stall_if,   eStall);
        checkOutput("stall_id",   stall_id,   eStall);
        checkOutput("flush_if",   flush_if,   eFlush);
        checkOutput("bubble_ex",  bubble_ex,  eBubbleEx);
        checkOutput("stall_mem",  stall_mem,  eMem);
        checkOutput("bubble_wb",  bubble_wb,  eMem);
        checkOutput("mem_err",    mem_err,    modelErr);
        checkOutput("ctrl_state", ctrl_state, modelState);
`ifdef PIPE_PERF_CNT_EN
        checkOutput("stall_cycles", stall_cycles, modelStalls);
        checkOutput("flush_cnt",    flush_cnt,    modelFlush);
`else
        checkOutput("stall_cycles", stall_cycles, 0);
        checkOutput("flush_cnt",    flush_cnt,    0);
`endif

        if (rst) begin
            modelState  = 0;
            waitElapsed = 0;
            modelErr    = 1'b0;
            modelStalls = '0;
            modelFlush  = '0;
        end else begin
            if (eStall && modelStalls != '1) modelStalls = modelStalls + 1;
            if (eFlush && modelFlush != '1)  modelFlush  = modelFlush + 1;
            if (modelState == 0 && mem_req && !mem_ready) begin
                modelState  = 1;
                waitElapsed = 0;
            end else if (modelState == 1) begin
                if (mem_ready) begin
                    modelState = 0;
                end else begin
                    waitElapsed++;
                    if (waitElapsed == MEM_TIMEOUT - 1) begin
                        modelState = 2;
                        modelErr   = 1'b1;
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic two, input logic ld, input logic [4:0] dest,
                                 input logic br, input logic req, input logic rdy);
        @(posedge clk);
        #1;
        rst = r; id_src1 = s1; id_src2 = s2; id_two_src = two;
        ex_mem_r_en = ld; ex_dest = dest; br_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    task automatic sampleCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitSeen;
        bit reachedErr;

        rst = 1'b1; id_src1 = 5'd5; id_src2 = 5'd0; id_two_src = 1'b0;
        ex_mem_r_en = 1'b1; ex_dest = 5'd5; br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;

        repeat (2) sampleCycle();
        checkOutput("reset stall_if",   stall_if,   0);
        checkOutput("reset flush_if",   flush_if,   0);
        checkOutput("reset stall_mem",  stall_mem,  0);
        checkOutput("reset ctrl_state", ctrl_state, 0);
        checkOutput("reset mem_err",    mem_err,    0);

        idleCycle();
        sampleCycle();

        applyStimulus(0, 5'd5, 5'd0, 0, 1, 5'd5, 0, 0, 0);
        sampleCycle();
        checkOutput("lu stall_if",  stall_if,  1);
        checkOutput("lu stall_id",  stall_id,  1);
        checkOutput("lu bubble_ex", bubble_ex, 1);
        idleCycle();
        sampleCycle();
        checkOutput("lu released stall_if",  stall_if,  0);
        checkOutput("lu released bubble_ex", bubble_ex, 0);

        applyStimulus(0, 5'd0, 5'd3, 0, 1, 5'd0, 0, 0, 0);
        sampleCycle();
        checkOutput("r0 no stall", stall_if, 0);
        applyStimulus(0, 5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 0);
        sampleCycle();
        checkOutput("src2 unused no stall", stall_if, 0);

        applyStimulus(0, 5'd5, 5'd0, 0, 1, 5'd5, 1, 0, 0);
        sampleCycle();
        checkOutput("br flush_if",  flush_if,  1);
        checkOutput("br bubble_ex", bubble_ex, 1);
        checkOutput("br stall_if",  stall_if,  0);

        idleCycle();
        sampleCycle();
`ifdef PIPE_PERF_CNT_EN
        checkOutput("perf stall_cycles", stall_cycles, 1);
        checkOutput("perf flush_cnt",    flush_cnt,    1);
`else
        checkOutput("perf stall_cycles off", stall_cycles, 0);
        checkOutput("perf flush_cnt off",    flush_cnt,    0);
`endif

        applyStimulus(0, 5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 0);
        sampleCycle();
        checkOutput("src2 used stall", stall_if, 1);

        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        sampleCycle();
        checkOutput("mw1 bubble_wb",  bubble_wb,  1);
        checkOutput("mw1 ctrl_state", ctrl_state, 0);
        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        sampleCycle();
        checkOutput("mw2 ctrl_state", ctrl_state, 1);
        checkOutput("mw2 stall_mem",  stall_mem,  1);
        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 0);
        sampleCycle();
        checkOutput("mw3 br held flush_if", flush_if,  0);
        checkOutput("mw3 bubble_wb",        bubble_wb, 1);
        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 1);
        sampleCycle();
        checkOutput("mw ready bubble_wb", bubble_wb, 0);
        checkOutput("mw ready flush_if",  flush_if,  1);
        checkOutput("mw ready state",     ctrl_state, 1);
        idleCycle();
        sampleCycle();
        checkOutput("mw done state", ctrl_state, 0);

        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
        sampleCycle();
        checkOutput("single-cycle mem stall_if", stall_if, 0);

        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        sampleCycle();
        waitSeen   = 0;
        reachedErr = 1'b0;
        for (int i = 0; i < 3 * MEM_TIMEOUT; i++) begin
            applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
            sampleCycle();
            if (ctrl_state == 2'd2) begin
                reachedErr = 1'b1;
                break;
            end
            if (ctrl_state == 2'd1) waitSeen++;
        end
        checkOutput("timeout reached ERR", reachedErr, 1);
        checkOutput("timeout wait cycles", waitSeen, 15);
        checkOutput("timeout mem_err", mem_err, 1);

        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 1);
        sampleCycle();
        checkOutput("err ignores ready state", ctrl_state, 2);
        checkOutput("err stall_if",            stall_if,   1);
        idleCycle();
        sampleCycle();
        checkOutput("err sticky", mem_err, 1);

        applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 0);
        sampleCycle();
        checkOutput("rst in ERR stall_if", stall_if, 0);
        idleCycle();
        sampleCycle();
        checkOutput("rst clears mem_err", mem_err,    0);
        checkOutput("rst clears state",   ctrl_state, 0);

        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        applyStimulus(0, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        sampleCycle();
        checkOutput("pre-rst wait state", ctrl_state, 1);
        applyStimulus(1, 5'd1, 5'd2, 1, 0, 5'd0, 0, 1, 0);
        sampleCycle();
        checkOutput("rst mid-wait stall_mem", stall_mem, 0);
        idleCycle();
        sampleCycle();
        checkOutput("rst mid-wait state", ctrl_state, 0);

        idleCycle();
        sampleCycle();
        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
